// File: rtl/decode_hazard_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : decode_hazard_pipeline
// Brief    : ID stage (regfile, branch resolve, hazard stall/replay) + ID/EX.
// Revision : 1.0 - initial release
// ============================================================================
module decode_hazard_pipeline #(
    parameter int PC_W = 16,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_D,
    input  logic [PC_W-1:0] pc_D,
    input  logic [PC_W-1:0] pc_plus4D,
    input  logic [4:0]      rd_M,
    input  logic            reg_write_M,
    input  logic            mem_read_M,
    input  logic [XLEN-1:0] alu_result_M,
    input  logic [4:0]      rd_W,
    input  logic            reg_write_W,
    input  logic [XLEN-1:0] result_W,
    output logic            pc_src,
    output logic [PC_W-1:0] dest_pc,
    output logic            pc_write_zero,
    output logic            IF_pipeline_write_zero,
    output logic [XLEN-1:0] rs1_data_E,
    output logic [XLEN-1:0] rs2_data_E,
    output logic [XLEN-1:0] imm_E,
    output logic [4:0]      rs1_E,
    output logic [4:0]      rs2_E,
    output logic [4:0]      rd_E,
    output logic [PC_W-1:0] pc_E,
    output logic [PC_W-1:0] pc_plus4_E,
    output logic [6:0]      opcode_E,
    output logic [2:0]      funct3_E,
    output logic            funct7b5_E,
    output logic            reg_write_E,
    output logic            mem_read_E,
    output logic            mem_write_E
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pc_plus4;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } idex_t;

    idex_t           idex_q, idex_d;
    logic            replay_valid_q;
    logic [31:0]     replay_q;
    logic [PC_W-1:0] replay_pc_q, replay_pc4_q;
    logic [XLEN-1:0] regs_q [32];

    logic [31:0]     w_instr;
    logic [PC_W-1:0] w_pc, w_pc4;
    logic [6:0]      w_op;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic [2:0]      w_f3;
    logic            w_is_r, w_is_i, w_is_load, w_is_store, w_is_br, w_is_jal, w_is_lui;
    logic            w_use_rs1, w_use_rs2, w_reg_write;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm, w_rf1, w_rf2, w_cmp1, w_cmp2;
    logic            w_hz_load, w_hz_br_e, w_hz_br_m, w_stall, w_taken;

    // IF/ID is overwritten while the PC is held, so a stalled instruction comes from replay
    assign w_instr = replay_valid_q ? replay_q     : instr_D;
    assign w_pc    = replay_valid_q ? replay_pc_q  : pc_D;
    assign w_pc4   = replay_valid_q ? replay_pc4_q : pc_plus4D;

    assign w_op  = w_instr[6:0];
    assign w_rd  = w_instr[11:7];
    assign w_f3  = w_instr[14:12];
    assign w_rs1 = w_instr[19:15];
    assign w_rs2 = w_instr[24:20];

    assign w_is_r     = (w_op == c_OP_R);
    assign w_is_i     = (w_op == c_OP_I);
    assign w_is_load  = (w_op == c_OP_LOAD);
    assign w_is_store = (w_op == c_OP_STORE);
    assign w_is_br    = (w_op == c_OP_BRANCH);
    assign w_is_jal   = (w_op == c_OP_JAL);
    assign w_is_lui   = (w_op == c_OP_LUI);

    assign w_use_rs1   = w_is_r | w_is_i | w_is_load | w_is_store | w_is_br;
    assign w_use_rs2   = w_is_r | w_is_store | w_is_br;
    assign w_reg_write = (w_is_r | w_is_i | w_is_load | w_is_jal | w_is_lui) && (w_rd != 5'd0);

    always_comb begin
        w_imm32 = 32'd0;
        unique case (w_op)
            c_OP_I, c_OP_LOAD: w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
            c_OP_STORE:        w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            c_OP_BRANCH:       w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                                          w_instr[30:25], w_instr[11:8], 1'b0};
            c_OP_JAL:          w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                                          w_instr[20], w_instr[30:21], 1'b0};
            c_OP_LUI:          w_imm32 = {w_instr[31:12], 12'd0};
            default:           w_imm32 = 32'd0;
        endcase
    end
    assign w_imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

    always_ff @(posedge clk) begin
        if (reg_write_W && (rd_W != 5'd0)) begin
            regs_q[rd_W] <= result_W;
        end
    end

    assign w_rf1 = (w_rs1 == 5'd0) ? '0 :
                   (reg_write_W && (rd_W == w_rs1)) ? result_W : regs_q[w_rs1];
    assign w_rf2 = (w_rs2 == 5'd0) ? '0 :
                   (reg_write_W && (rd_W == w_rs2)) ? result_W : regs_q[w_rs2];

    // Only non-load MEM results are ready in time for the ID compare
    assign w_cmp1 = (reg_write_M && !mem_read_M && (rd_M == w_rs1) && (w_rs1 != 5'd0)) ? alu_result_M : w_rf1;
    assign w_cmp2 = (reg_write_M && !mem_read_M && (rd_M == w_rs2) && (w_rs2 != 5'd0)) ? alu_result_M : w_rf2;

    assign w_hz_load = idex_q.mem_read && (idex_q.rd != 5'd0) &&
                       ((w_use_rs1 && (idex_q.rd == w_rs1)) || (w_use_rs2 && (idex_q.rd == w_rs2)));
    assign w_hz_br_e = w_is_br && idex_q.reg_write && (idex_q.rd != 5'd0) &&
                       ((idex_q.rd == w_rs1) || (idex_q.rd == w_rs2));
    assign w_hz_br_m = w_is_br && mem_read_M && (rd_M != 5'd0) &&
                       ((rd_M == w_rs1) || (rd_M == w_rs2));
    assign w_stall   = !reset && (w_hz_load || w_hz_br_e || w_hz_br_m);

    assign w_taken = !reset && !w_stall &&
                     ((w_is_br && (w_f3 == 3'b000) && (w_cmp1 == w_cmp2)) ||
                      (w_is_br && (w_f3 == 3'b001) && (w_cmp1 != w_cmp2)) ||
                      w_is_jal);

    assign pc_src                 = w_taken;
    assign IF_pipeline_write_zero = w_taken;
    assign pc_write_zero          = w_stall;
    assign dest_pc                = w_taken ? (w_pc + w_imm[PC_W-1:0]) : '0;

    always_comb begin
        idex_d = '0;
        if (!w_stall) begin
            idex_d.rs1_data  = w_rf1;
            idex_d.rs2_data  = w_rf2;
            idex_d.imm       = w_imm;
            idex_d.rs1       = w_rs1;
            idex_d.rs2       = w_rs2;
            idex_d.rd        = w_rd;
            idex_d.pc        = w_pc;
            idex_d.pc_plus4  = w_pc4;
            idex_d.opcode    = w_op;
            idex_d.funct3    = w_f3;
            idex_d.funct7b5  = w_instr[30];
            idex_d.reg_write = w_reg_write;
            idex_d.mem_read  = w_is_load;
            idex_d.mem_write = w_is_store;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q         <= '0;
            replay_valid_q <= 1'b0;
            replay_q       <= '0;
            replay_pc_q    <= '0;
            replay_pc4_q   <= '0;
        end else begin
            idex_q         <= idex_d;
            replay_valid_q <= w_stall;
            if (w_stall) begin
                replay_q     <= w_instr;
                replay_pc_q  <= w_pc;
                replay_pc4_q <= w_pc4;
            end
        end
    end

    assign rs1_data_E  = idex_q.rs1_data;
    assign rs2_data_E  = idex_q.rs2_data;
    assign imm_E       = idex_q.imm;
    assign rs1_E       = idex_q.rs1;
    assign rs2_E       = idex_q.rs2;
    assign rd_E        = idex_q.rd;
    assign pc_E        = idex_q.pc;
    assign pc_plus4_E  = idex_q.pc_plus4;
    assign opcode_E    = idex_q.opcode;
    assign funct3_E    = idex_q.funct3;
    assign funct7b5_E  = idex_q.funct7b5;
    assign reg_write_E = idex_q.reg_write;
    assign mem_read_E  = idex_q.mem_read;
    assign mem_write_E = idex_q.mem_write;

endmodule
`default_nettype wire

// File: tb/tb_decode_hazard_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_hazard_pipeline
// Brief    : Directed self-checking bench for decode_hazard_pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_hazard_pipeline;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_D;
    logic [15:0] pc_D, pc_plus4D;
    logic [4:0]  rd_M, rd_W;
    logic        reg_write_M, mem_read_M, reg_write_W;
    logic [31:0] alu_result_M, result_W;
    logic        pc_src, pc_write_zero, IF_pipeline_write_zero;
    logic [15:0] dest_pc, pc_E, pc_plus4_E;
    logic [31:0] rs1_data_E, rs2_data_E, imm_E;
    logic [4:0]  rs1_E, rs2_E, rd_E;
    logic [6:0]  opcode_E;
    logic [2:0]  funct3_E;
    logic        funct7b5_E, reg_write_E, mem_read_E, mem_write_E;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] c_LW     = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] c_ADD    = 32'h00228333; // add  x6,x5,x2
    localparam logic [31:0] c_BEQ    = 32'h00208863; // beq  x1,x2,+16
    localparam logic [31:0] c_BNE    = 32'h00209863; // bne  x1,x2,+16
    localparam logic [31:0] c_ADDI3  = 32'h00500193; // addi x3,x0,5
    localparam logic [31:0] c_BNE_M8 = 32'hFE019CE3; // bne  x3,x0,-8
    localparam logic [31:0] c_ADDI9  = 32'h00000493; // addi x9,x0,0
    localparam logic [31:0] c_ADDI10 = 32'h00020513; // addi x10,x4,0
    localparam logic [31:0] c_JAL    = 32'h008000EF; // jal  x1,+8
    localparam logic [31:0] c_SW     = 32'h0020A623; // sw   x2,12(x1)

    logic [169:0] all_e;
    assign all_e = {rs1_data_E, rs2_data_E, imm_E, rs1_E, rs2_E, rd_E, pc_E, pc_plus4_E,
                    opcode_E, funct3_E, funct7b5_E, reg_write_E, mem_read_E, mem_write_E};

    decode_hazard_pipeline #(.PC_W(16), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .instr_D(instr_D), .pc_D(pc_D), .pc_plus4D(pc_plus4D),
        .rd_M(rd_M), .reg_write_M(reg_write_M), .mem_read_M(mem_read_M), .alu_result_M(alu_result_M),
        .rd_W(rd_W), .reg_write_W(reg_write_W), .result_W(result_W),
        .pc_src(pc_src), .dest_pc(dest_pc), .pc_write_zero(pc_write_zero),
        .IF_pipeline_write_zero(IF_pipeline_write_zero),
        .rs1_data_E(rs1_data_E), .rs2_data_E(rs2_data_E), .imm_E(imm_E),
        .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .pc_E(pc_E), .pc_plus4_E(pc_plus4_E),
        .opcode_E(opcode_E), .funct3_E(funct3_E), .funct7b5_E(funct7b5_E),
        .reg_write_E(reg_write_E), .mem_read_E(mem_read_E), .mem_write_E(mem_write_E)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [31:0] ins, input logic [15:0] pc);
        instr_D   = ins;
        pc_D      = pc;
        pc_plus4D = pc + 16'd4;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_d(32'h0, 16'h0);
        rd_M = '0; reg_write_M = 1'b0; mem_read_M = 1'b0; alu_result_M = '0;
        rd_W = '0; reg_write_W = 1'b0; result_W = '0;
        tick; tick;
        checks++; if (all_e !== '0) begin errors++; $display("FAIL reset_idex: got %0h expected 0", all_e); end
        checks++; if ({pc_src, pc_write_zero, IF_pipeline_write_zero} !== 3'b000) begin errors++; $display("FAIL reset_fetch: got %b expected 000", {pc_src, pc_write_zero, IF_pipeline_write_zero}); end
        reset = 1'b0;
        #1;
        checks++; if ({pc_src, pc_write_zero, IF_pipeline_write_zero, dest_pc} !== 19'd0) begin errors++; $display("FAIL post_reset_fetch: got %0h expected 0", {pc_src, pc_write_zero, IF_pipeline_write_zero, dest_pc}); end
    endtask

    task automatic test_load_use;
        set_d(c_LW, 16'h0010); #1;
        checks++; if (pc_write_zero !== 1'b0) begin errors++; $display("FAIL lu_lw_nostall: got %b expected 0", pc_write_zero); end
        tick;
        checks++; if ({mem_read_E, rd_E} !== {1'b1, 5'd5}) begin errors++; $display("FAIL lu_lw_in_e: got %0h expected 25", {mem_read_E, rd_E}); end
        set_d(c_ADD, 16'h0014); #1;
        checks++; if ({pc_write_zero, pc_src, IF_pipeline_write_zero} !== 3'b100) begin errors++; $display("FAIL lu_stall: got %b expected 100", {pc_write_zero, pc_src, IF_pipeline_write_zero}); end
        tick;
        checks++; if (all_e !== '0) begin errors++; $display("FAIL lu_bubble: got %0h expected 0", all_e); end
        set_d(c_ADDI9, 16'h0018); #1;
        checks++; if (pc_write_zero !== 1'b0) begin errors++; $display("FAIL lu_stall_once: got %b expected 0", pc_write_zero); end
        tick;
        checks++; if ({pc_E, pc_plus4_E, rs1_E, rs2_E, rd_E, reg_write_E} !== {16'h0014, 16'h0018, 5'd5, 5'd2, 5'd6, 1'b1}) begin errors++; $display("FAIL lu_replay: got pc=%0h pc4=%0h rs1=%0d rs2=%0d rd=%0d rw=%b expected 14 18 5 2 6 1", pc_E, pc_plus4_E, rs1_E, rs2_E, rd_E, reg_write_E); end
        set_d(32'h0, 16'h0); tick;
    endtask

    task automatic test_taken_branch;
        rd_W = 5'd1; result_W = 32'd7; reg_write_W = 1'b1; tick;
        rd_W = 5'd2; tick;
        reg_write_W = 1'b0;
        set_d(c_BEQ, 16'h0020); #1;
        checks++; if ({pc_src, IF_pipeline_write_zero, pc_write_zero, dest_pc} !== {3'b110, 16'h0030}) begin errors++; $display("FAIL beq_taken: got src=%b flush=%b hold=%b dest=%0h expected 1 1 0 30", pc_src, IF_pipeline_write_zero, pc_write_zero, dest_pc); end
        tick;
        checks++; if ({imm_E, rs1_data_E, rs2_data_E, opcode_E, reg_write_E} !== {32'd16, 32'd7, 32'd7, 7'h63, 1'b0}) begin errors++; $display("FAIL beq_idex: got imm=%0h a=%0h b=%0h op=%0h rw=%b expected 10 7 7 63 0", imm_E, rs1_data_E, rs2_data_E, opcode_E, reg_write_E); end
        set_d(c_BNE, 16'h0020); #1;
        checks++; if ({pc_src, IF_pipeline_write_zero, dest_pc} !== 18'd0) begin errors++; $display("FAIL bne_not_taken: got src=%b flush=%b dest=%0h expected 0 0 0", pc_src, IF_pipeline_write_zero, dest_pc); end
        tick;
        set_d(32'h0, 16'h0); tick;
    endtask

    task automatic test_branch_hazard;
        set_d(c_ADDI3, 16'h003C); tick;
        checks++; if ({reg_write_E, rd_E, imm_E} !== {1'b1, 5'd3, 32'd5}) begin errors++; $display("FAIL bh_addi: got rw=%b rd=%0d imm=%0h expected 1 3 5", reg_write_E, rd_E, imm_E); end
        set_d(c_BNE_M8, 16'h0040); #1;
        checks++; if ({pc_write_zero, pc_src, IF_pipeline_write_zero} !== 3'b100) begin errors++; $display("FAIL bh_stall: got %b expected 100", {pc_write_zero, pc_src, IF_pipeline_write_zero}); end
        tick;
        set_d(32'h00000013, 16'h0044);
        rd_M = 5'd3; reg_write_M = 1'b1; mem_read_M = 1'b0; alu_result_M = 32'd5; #1;
        checks++; if ({pc_write_zero, pc_src, IF_pipeline_write_zero, dest_pc} !== {3'b011, 16'h0038}) begin errors++; $display("FAIL bh_fwd_taken: got hold=%b src=%b flush=%b dest=%0h expected 0 1 1 38", pc_write_zero, pc_src, IF_pipeline_write_zero, dest_pc); end
        tick;
        checks++; if ({pc_E, imm_E, funct3_E} !== {16'h0040, 32'hFFFF_FFF8, 3'b001}) begin errors++; $display("FAIL bh_idex: got pc=%0h imm=%0h f3=%0d expected 40 fffffff8 1", pc_E, imm_E, funct3_E); end
        rd_M = '0; reg_write_M = 1'b0; alu_result_M = '0;
        set_d(32'h0, 16'h0); tick;
    endtask

    task automatic test_x0_bypass;
        rd_W = 5'd0; result_W = 32'hFFFF_FFFF; reg_write_W = 1'b1;
        set_d(c_ADDI9, 16'h0050); tick;
        checks++; if (rs1_data_E !== 32'd0) begin errors++; $display("FAIL x0_bypass: got %0h expected 0", rs1_data_E); end
        reg_write_W = 1'b0; tick;
        checks++; if (rs1_data_E !== 32'd0) begin errors++; $display("FAIL x0_read: got %0h expected 0", rs1_data_E); end
        rd_W = 5'd4; result_W = 32'h1234; reg_write_W = 1'b1;
        set_d(c_ADDI10, 16'h0054); tick;
        checks++; if (rs1_data_E !== 32'h1234) begin errors++; $display("FAIL wb_bypass: got %0h expected 1234", rs1_data_E); end
        reg_write_W = 1'b0; result_W = '0;
        set_d(c_ADDI10, 16'h0058); tick;
        checks++; if (rs1_data_E !== 32'h1234) begin errors++; $display("FAIL rf_write: got %0h expected 1234", rs1_data_E); end
        set_d(32'h0, 16'h0); tick;
    endtask

    task automatic test_jal_store;
        set_d(c_JAL, 16'h0100); #1;
        checks++; if ({pc_src, IF_pipeline_write_zero, dest_pc} !== {2'b11, 16'h0108}) begin errors++; $display("FAIL jal_redirect: got src=%b flush=%b dest=%0h expected 1 1 108", pc_src, IF_pipeline_write_zero, dest_pc); end
        tick;
        checks++; if ({reg_write_E, rd_E, imm_E, pc_plus4_E} !== {1'b1, 5'd1, 32'd8, 16'h0104}) begin errors++; $display("FAIL jal_idex: got rw=%b rd=%0d imm=%0h pc4=%0h expected 1 1 8 104", reg_write_E, rd_E, imm_E, pc_plus4_E); end
        set_d(c_SW, 16'h0200); #1;
        checks++; if (pc_write_zero !== 1'b0) begin errors++; $display("FAIL sw_nostall: got %b expected 0", pc_write_zero); end
        tick;
        checks++; if ({mem_write_E, reg_write_E, mem_read_E, imm_E, rs2_data_E} !== {3'b100, 32'd12, 32'd7}) begin errors++; $display("FAIL sw_idex: got mw=%b rw=%b mr=%b imm=%0h b=%0h expected 1 0 0 c 7", mem_write_E, reg_write_E, mem_read_E, imm_E, rs2_data_E); end
        set_d(32'hFFFF_FFFF, 16'h0204); tick;
        checks++; if ({reg_write_E, mem_read_E, mem_write_E} !== 3'b000) begin errors++; $display("FAIL bad_opcode: got %b expected 000", {reg_write_E, mem_read_E, mem_write_E}); end
        set_d(32'h0, 16'h0); tick;
    endtask

    task automatic test_reset_during_stall;
        set_d(c_LW, 16'h0010); tick;
        set_d(c_ADD, 16'h0014); reset = 1'b1; #1;
        checks++; if ({pc_write_zero, pc_src, IF_pipeline_write_zero} !== 3'b000) begin errors++; $display("FAIL rst_overrides_stall: got %b expected 000", {pc_write_zero, pc_src, IF_pipeline_write_zero}); end
        tick;
        checks++; if (all_e !== '0) begin errors++; $display("FAIL rst_stall_idex: got %0h expected 0", all_e); end
        reset = 1'b0;
        set_d(c_ADDI10, 16'h0080); #1;
        checks++; if (pc_write_zero !== 1'b0) begin errors++; $display("FAIL rst_no_stall: got %b expected 0", pc_write_zero); end
        tick;
        checks++; if ({pc_E, rd_E, rs1_data_E} !== {16'h0080, 5'd10, 32'h1234}) begin errors++; $display("FAIL rst_resume: got pc=%0h rd=%0d a=%0h expected 80 10 1234", pc_E, rd_E, rs1_data_E); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_taken_branch();
        test_branch_hazard();
        test_x0_bypass();
        test_jal_store();
        test_reset_during_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
